// File: rtl/conv_window_reader_pkg.sv
// Shared definitions for the convolution window reader: memory map, FSM states, defaults.
// Addresses select matrix A (bit4 = 0) or filter B (bit4 = 1), with index row*4 + col.
package conv_window_reader_pkg;

    localparam int DW_DEF   = 8;
    localparam int ACCW_DEF = 20;

    localparam logic [4:0] A_BASE     = 5'd0;
    localparam logic [4:0] B_BASE     = 5'd16;
    localparam logic [4:0] ROW_STRIDE = 5'd4;

    typedef enum logic [2:0] {
        IDLE,
        LOADF,
        MAC,
        HOLD,
        DONE
    } state_t;

    function automatic logic [4:0] cell_addr(input logic [4:0] base,
                                             input logic [2:0] row,
                                             input logic [2:0] col);
        return base + 5'(row) * ROW_STRIDE + 5'(col);
    endfunction

endpackage

// File: rtl/conv_window_reader_mac.sv
// One filter row per cycle: three unsigned DW x DW products summed into an ACCW accumulator.
// The clear input restarts the accumulation on the first row of a window.
module conv_row_mac
    import conv_window_reader_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic [DW-1:0]   d1,
    input  logic [DW-1:0]   d2,
    input  logic [DW-1:0]   d3,
    input  logic [DW-1:0]   f1,
    input  logic [DW-1:0]   f2,
    input  logic [DW-1:0]   f3,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] prod1, prod2, prod3;
    logic [ACCW-1:0] row_sum;
    logic [ACCW-1:0] acc_base;

    // ACCW is sized for nine full-scale products, so no saturation is required.
    always_comb begin
        prod1    = d1 * f1;
        prod2    = d2 * f2;
        prod3    = d3 * f3;
        row_sum  = ACCW'(prod1) + ACCW'(prod2) + ACCW'(prod3);
        acc_base = clear ? '0 : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_base + row_sum;
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Reads the 3x3 filter, then computes the four 2x2-valid convolution windows over the 4x4 input
// and presents each result on a valid/ready handshake.
module conv_window_reader
    import conv_window_reader_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [4:0]      address1,
    output logic [4:0]      address2,
    output logic [4:0]      address3,
    input  logic [DW-1:0]   mem_out1,
    input  logic [DW-1:0]   mem_out2,
    input  logic [DW-1:0]   mem_out3,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] res_data,
    output logic [1:0]      res_idx,
    output logic            done
);

    state_t          state;
    logic [1:0]      k;
    logic [1:0]      w;
    logic [DW-1:0]   filt [3][3];
    logic [ACCW-1:0] acc;
    logic [2:0]      mac_row;
    logic [2:0]      mac_col;

    // Window w = 2*r + c, so r is w[1] and c is w[0].
    assign mac_row = 3'(w[1]) + 3'(k);
    assign mac_col = 3'(w[0]);

    always_comb begin
        address1 = '0;
        address2 = '0;
        address3 = '0;
        case (state)
            LOADF: begin
                address1 = cell_addr(B_BASE, 3'(k), 3'd0);
                address2 = cell_addr(B_BASE, 3'(k), 3'd1);
                address3 = cell_addr(B_BASE, 3'(k), 3'd2);
            end
            MAC: begin
                address1 = cell_addr(A_BASE, mac_row, mac_col);
                address2 = cell_addr(A_BASE, mac_row, mac_col + 3'd1);
                address3 = cell_addr(A_BASE, mac_row, mac_col + 3'd2);
            end
            default: ;
        endcase
    end

    conv_row_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (state == MAC),
        .clear (k == 2'd0),
        .d1    (mem_out1),
        .d2    (mem_out2),
        .d3    (mem_out3),
        .f1    (filt[k][0]),
        .f2    (filt[k][1]),
        .f3    (filt[k][2]),
        .acc   (acc)
    );

    // The accumulator only moves in MAC, so the held result is stable for the whole HOLD.
    assign res_data = res_valid ? acc : '0;
    assign res_idx  = res_valid ? w : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            w         <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    filt[i][j] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOADF;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOADF: begin
                    filt[k][0] <= mem_out1;
                    filt[k][1] <= mem_out2;
                    filt[k][2] <= mem_out3;
                    if (k == 2'd2) begin
                        state <= MAC;
                        k     <= '0;
                        w     <= '0;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                MAC: begin
                    if (k == 2'd2) begin
                        state     <= HOLD;
                        k         <= '0;
                        res_valid <= 1'b1;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (w == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= MAC;
                            w     <= w + 2'd1;
                            k     <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
